// File: rtl/soc_timer_pkg.sv
// soc_timer shared definitions: register map, CTRL bits,
// FSM encoding, reset constants and a byte-lane merge helper.
package soc_timer_pkg;

  localparam logic [2:0] OFS_CTRL     = 3'd0;
  localparam logic [2:0] OFS_PRESCALE = 3'd1;
  localparam logic [2:0] OFS_COUNT    = 3'd2;
  localparam logic [2:0] OFS_COMPARE  = 3'd3;
  localparam logic [2:0] OFS_STATUS   = 3'd4;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_IE  = 1;
  localparam int CTRL_PER = 2;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [31:0] COUNT_RST   = 32'h0000_0000;
  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;
  localparam logic [31:0] DOUT_RST    = 32'h0000_0000;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/soc_timer_prescaler.sv
// Prescaler: free-runs while enabled and pulses tick whenever
// the counter reaches the programmed prescale value.
module timer_prescaler #(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;

  always_comb begin
    tick      = run && (pre_cnt_q == prescale);
    pre_cnt_d = pre_cnt_q + PRE_W'(1);
    if (!run || clr || tick) begin
      pre_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/soc_timer.sv
// Memory-mapped timer/compare peripheral on the data port,
// with one-cycle read latency and a level interrupt.
module soc_timer
  import soc_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hBFAF_F000,
  parameter int          PRE_W     = 16
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic [31:0] daddr,
  input  logic        dce,
  input  logic [3:0]  we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        hit,
  output logic        irq
);

  state_e           state_q, state_d;
  logic             ie_q, ie_d;
  logic             per_q, per_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      compare_q, compare_d;
  logic             pend_q, pend_d;
  logic [31:0]      dout_q, dout_d;
  logic             hit_q, hit_d;

  logic        sel, wr, rd, en, en_rise, tick, match;
  logic        wr_ctrl, wr_pre, wr_cnt, wr_cmp, w1c;
  logic [2:0]  ofs;
  logic [31:0] rdata;
  logic        unused_addr;

  assign unused_addr = ^daddr[1:0];

  timer_prescaler #(.PRE_W(PRE_W)) u_pre (
    .clk      (cpu_clk_50M),
    .rst_n    (cpu_rst_n),
    .run      (en),
    .clr      (en_rise),
    .prescale (prescale_q),
    .tick     (tick)
  );

  always_comb begin
    sel     = dce && (daddr[31:5] == BASE_ADDR[31:5]);
    ofs     = daddr[4:2];
    wr      = sel && (we != 4'h0);
    rd      = sel && (we == 4'h0);
    wr_ctrl = wr && (ofs == OFS_CTRL) && we[0];
    wr_pre  = wr && (ofs == OFS_PRESCALE);
    wr_cnt  = wr && (ofs == OFS_COUNT);
    wr_cmp  = wr && (ofs == OFS_COMPARE);
    w1c     = wr && (ofs == OFS_STATUS) && we[0] && din[0];
    en      = (state_q == ST_RUN);
    en_rise = wr_ctrl && din[CTRL_EN] && !en;
    // A software COUNT write suppresses match evaluation.
    match   = tick && !wr_cnt && (count_q == compare_q);
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      ofs == OFS_CTRL:     rdata = {29'b0, per_q, ie_q, en};
      ofs == OFS_PRESCALE: rdata = 32'(prescale_q);
      ofs == OFS_COUNT:    rdata = count_q;
      ofs == OFS_COMPARE:  rdata = compare_q;
      ofs == OFS_STATUS:   rdata = {31'b0, pend_q};
      default:             rdata = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ie_d       = ie_q;
    per_d      = per_q;
    prescale_d = prescale_q;
    count_d    = count_q;
    compare_d  = compare_q;
    pend_d     = pend_q;
    dout_d     = rd ? rdata : dout_q;
    hit_d      = rd;

    unique case (state_q)
      ST_STOP: if (wr_ctrl && din[CTRL_EN]) state_d = ST_RUN;
      ST_RUN:  if (match && !per_q) state_d = ST_STOP;
      default: state_d = ST_STOP;
    endcase
    // Software EN write overrides the one-shot auto-stop.
    if (wr_ctrl) begin
      state_d = din[CTRL_EN] ? ST_RUN : ST_STOP;
      ie_d    = din[CTRL_IE];
      per_d   = din[CTRL_PER];
    end

    if (wr_pre) begin
      prescale_d = PRE_W'(be_merge(32'(prescale_q), din, we));
    end
    if (wr_cmp) begin
      compare_d = be_merge(compare_q, din, we);
    end

    if (wr_cnt) begin
      count_d = be_merge(count_q, din, we);
    end else if (tick) begin
      count_d = match ? '0 : count_q + 32'd1;
    end

    if (w1c)   pend_d = 1'b0;
    if (match) pend_d = 1'b1;
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q    <= ST_STOP;
      ie_q       <= 1'b0;
      per_q      <= 1'b0;
      prescale_q <= '0;
      count_q    <= COUNT_RST;
      compare_q  <= COMPARE_RST;
      pend_q     <= 1'b0;
      dout_q     <= DOUT_RST;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ie_q       <= ie_d;
      per_q      <= per_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      pend_q     <= pend_d;
      dout_q     <= dout_d;
      hit_q      <= hit_d;
    end
  end

  assign dout = dout_q;
  assign hit  = hit_q;
  assign irq  = pend_q & ie_q;

endmodule

// File: tb/tb_soc_timer.sv
// Bench for soc_timer: directed and random bus traffic checked
// through a read-data scoreboard fed by a behavioural model.
module tb_soc_timer;

  localparam logic [31:0] BASE = 32'hBFAF_F000;

  logic        clk;
  logic        rst_n;
  logic [31:0] daddr;
  logic        dce;
  logic [3:0]  we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        hit;
  logic        irq;

  int n_vec;
  int n_err;

  soc_timer dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .daddr       (daddr),
    .dce         (dce),
    .we          (we),
    .din         (din),
    .dout        (dout),
    .hit         (hit),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        m_en, m_ie, m_per, m_pend;
  logic [15:0] m_pre, m_pcnt;
  logic [31:0] m_cnt, m_cmp;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] bmerge(input logic [31:0] o,
                                         input logic [31:0] n,
                                         input logic [3:0] b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = b[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] reg_value(input logic [2:0] off);
    case (off)
      3'd0:    return {29'b0, m_per, m_ie, m_en};
      3'd1:    return {16'b0, m_pre};
      3'd2:    return m_cnt;
      3'd3:    return m_cmp;
      3'd4:    return {31'b0, m_pend};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_ie = 0; m_per = 0; m_pend = 0;
    m_pre = 0; m_pcnt = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF;
  endtask

  // One clock of the timer as described by its register rules.
  task automatic model_step(input logic [31:0] a, input logic ce,
                            input logic [3:0] w, input logic [31:0] d);
    logic in_win, is_wr, tck, cnt_wr, matched;
    logic [2:0] off;
    logic [31:0] pre32;
    in_win = ce && (a[31:5] == BASE[31:5]);
    off = a[4:2];
    is_wr = in_win && (w != 4'h0);
    if (in_win && w == 4'h0) exp_q.push_back(reg_value(off));
    tck = m_en && (m_pcnt == m_pre);
    cnt_wr = is_wr && off == 3'd2;
    matched = tck && !cnt_wr && (m_cnt == m_cmp);
    m_pcnt = (m_en && !tck) ? m_pcnt + 16'd1 : 16'd0;
    if (cnt_wr) m_cnt = bmerge(m_cnt, d, w);
    else if (tck) m_cnt = matched ? 32'd0 : m_cnt + 32'd1;
    if (is_wr && off == 3'd4 && w[0] && d[0]) m_pend = 0;
    if (matched) m_pend = 1;
    if (matched && !m_per) m_en = 0;
    if (is_wr && off == 3'd0 && w[0]) begin
      m_en = d[0]; m_ie = d[1]; m_per = d[2];
    end
    if (is_wr && off == 3'd1) begin
      pre32 = bmerge({16'b0, m_pre}, d, w);
      m_pre = pre32[15:0];
    end
    if (is_wr && off == 3'd3) m_cmp = bmerge(m_cmp, d, w);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
      exp_q.delete();
    end else begin
      model_step(daddr, dce, we, din);
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    logic eh;
    eh = (exp_q.size() != 0);
    n_vec++;
    if (hit !== eh) begin
      n_err++;
      $display("FAIL hit: got %b expected %b at %0t", hit, eh, $time);
    end
    if (eh) begin
      e = exp_q.pop_front();
      n_vec++;
      if (dout !== e) begin
        n_err++;
        $display("FAIL dout: got %h expected %h at %0t", dout, e, $time);
      end
    end
    n_vec++;
    if (irq !== (m_pend & m_ie)) begin
      n_err++;
      $display("FAIL irq: got %b expected %b at %0t", irq, m_pend & m_ie, $time);
    end
  end

  task automatic op(input logic [31:0] a, input logic ce,
                    input logic [3:0] w, input logic [31:0] d);
    @(posedge clk);
    #1;
    daddr = a; dce = ce; we = w; din = d;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    op(BASE | {27'b0, off, 2'b00}, 1'b1, 4'hF, d);
  endtask

  task automatic rd(input logic [2:0] off);
    op(BASE | {27'b0, off, 2'b00}, 1'b1, 4'h0, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(32'h0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0] w;
    logic [2:0] off;
    n_vec = 0; n_err = 0;
    rst_n = 0; daddr = 0; dce = 0; we = 0; din = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1;

    for (int i = 0; i < 8; i++) rd(3'(i));
    wr(3'd3, 32'h1234_5678);
    op(BASE | 32'hC, 1'b1, 4'b0001, 32'h0000_00AA);
    rd(3'd3);
    rd(3'd5);
    op(BASE + 32'h20, 1'b1, 4'h0, 32'h0);
    op(BASE ^ 32'h8000_0000, 1'b1, 4'h0, 32'h0);
    op(BASE | 32'h4, 1'b0, 4'h0, 32'h0);

    // Periodic run, latency reads, W1C on the second match cycle.
    wr(3'd1, 32'd0);
    wr(3'd3, 32'd3);
    wr(3'd0, 32'd7);
    for (int i = 0; i < 7; i++) rd(3'd2);
    op(BASE | 32'h10, 1'b1, 4'b0001, 32'h1);
    rd(3'd4);
    rd(3'd0);
    idle(3);

    // COUNT write on a tick cycle, then wrap with no match.
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd1);
    wr(3'd3, 32'd5);
    wr(3'd0, 32'd5);
    idle(1);
    wr(3'd2, 32'hFFFF_FFFE);
    rd(3'd2); rd(3'd2); rd(3'd2); rd(3'd4);

    // Reset while running with PEND and IE set.
    wr(3'd3, 32'd2);
    wr(3'd2, 32'd0);
    wr(3'd0, 32'd7);
    idle(6);
    rd(3'd3);
    idle(1);
    #2 rst_n = 0;
    #1;
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_hit", {31'b0, hit}, 32'h0);
    chk("rst_dout", dout, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    rd(3'd3);
    rd(3'd0);
    rd(3'd2);

    // One-shot.
    wr(3'd1, 32'd2);
    wr(3'd3, 32'd1);
    wr(3'd0, 32'd3);
    idle(8);
    rd(3'd0); rd(3'd2); rd(3'd4);
    idle(4);
    rd(3'd2);

    for (int i = 0; i < 3000; i++) begin
      off = 3'($urandom_range(0, 7));
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      case (off)
        3'd1: d = $urandom_range(0, 3);
        3'd2: d = ($urandom_range(0, 3) == 0) ?
                  32'hFFFF_FFF0 + $urandom_range(0, 15) :
                  32'($urandom_range(0, 12));
        3'd3: d = $urandom_range(0, 12);
        default: d = $urandom;
      endcase
      a = BASE | {27'b0, off, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0)
        a = a ^ (32'h1 << $urandom_range(5, 31));
      op(a, $urandom_range(0, 7) != 0, w, d);
    end

    idle(4);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d reads never returned hit", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
